// File: rtl/adder.sv
// rtl/adder.sv - one-bit full adder with registered result and optional carry-event counter
//
// Purpose:
//   Combinational full adder (S, Cout) plus a registered copy of the result.
//   A valid flag marks the point where the registered copy holds a sampled value.
//   When the macro ADDER_CARRY_CNT_EN is defined, a saturating counter of
//   carry events (edges where Cout is 1) and its carry_cnt port are added.
//   When the macro is undefined, neither the counter nor the port exists.
//
// Parameters:
//   CNT_W      width of the carry-event counter, 1..32 (default 8)
//
// Ports:
//   S          out  combinational sum, A ^ B ^ Cin
//   Cout       out  combinational carry-out, majority(A, B, Cin)
//   A, B       in   addends
//   Cin        in   carry-in
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   S_q        out  S sampled at the last rising edge
//   Cout_q     out  Cout sampled at the last rising edge
//   valid_q    out  high once S_q / Cout_q hold a sampled result
//   carry_cnt  out  saturating carry-event count (ADDER_CARRY_CNT_EN only)
//
// The first five ports are S, Cout, A, B, Cin so that a legacy five-port
// positional instance still connects the adder and leaves clk/rst_n open.

module adder #(
    parameter int CNT_W = 8
) (
    output logic             S,
    output logic             Cout,
    input  logic             A,
    input  logic             B,
    input  logic             Cin,
    input  logic             clk,
    input  logic             rst_n,
    output logic             S_q,
    output logic             Cout_q,
    output logic             valid_q
`ifdef ADDER_CARRY_CNT_EN
    ,
    output logic [CNT_W-1:0] carry_cnt
`endif
);

    generate
        if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
            $error("adder: CNT_W must be in 1..32");
        end
    endgenerate

    // Combinational full adder; independent of clock and reset.
    always_comb begin
        S    = A ^ B ^ Cin;
        Cout = (A & B) | (A & Cin) | (B & Cin);
    end

    logic s_d;
    logic cout_d;
    logic valid_d;

    always_comb begin
        s_d     = S;
        cout_d  = Cout;
        valid_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S_q     <= 1'b0;
            Cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            S_q     <= s_d;
            Cout_q  <= cout_d;
            valid_q <= valid_d;
        end
    end

`ifdef ADDER_CARRY_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count on the live Cout at each edge; hold once all-ones is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (Cout && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign carry_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_adder.sv
// tb/tb_adder.sv - self-checking bench for adder

module tb_adder;

`ifdef ADDER_CARRY_CNT_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 8;
`endif

    logic clk;
    logic rst_n;
    logic a, b, cin;
    logic s, cout;
    logic s_q, cout_q, valid_q;
`ifdef ADDER_CARRY_CNT_EN
    logic [CNT_W-1:0] carry_cnt;
`endif

    logic clk_run;
    int   total;
    int   bad;

    adder #(.CNT_W(CNT_W)) dut (
        .S         (s),
        .Cout      (cout),
        .A         (a),
        .B         (b),
        .Cin       (cin),
        .clk       (clk),
        .rst_n     (rst_n),
        .S_q       (s_q),
        .Cout_q    (cout_q),
        .valid_q   (valid_q)
`ifdef ADDER_CARRY_CNT_EN
        ,
        .carry_cnt (carry_cnt)
`endif
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic a;
        logic b;
        logic cin;
        logic s;
        logic cout;
    } vec_t;

    vec_t vecs[8];

    initial begin
        total   = 0;
        bad     = 0;
        clk_run = 1'b0;
        rst_n   = 1'b0;
        a = 1'b0; b = 1'b0; cin = 1'b0;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        #1;
        check("rst_s_q", 32'(s_q), 32'd0);
        check("rst_cout_q", 32'(cout_q), 32'd0);
        check("rst_valid_q", 32'(valid_q), 32'd0);
`ifdef ADDER_CARRY_CNT_EN
        check("rst_carry_cnt", 32'(carry_cnt), 32'd0);
`endif

        // Exhaustive sweep, no clock, reset held low.
        for (int i = 0; i < 8; i++) begin
            a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin;
            #1;
            check($sformatf("sweep%0d_s", i), 32'(s), 32'(vecs[i].s));
            check($sformatf("sweep%0d_cout", i), 32'(cout), 32'(vecs[i].cout));
        end

        // Latency: release reset with clock stopped, then one edge.
        rst_n = 1'b1;
        a = 1'b1; b = 1'b1; cin = 1'b0;
        #1;
        check("lat_pre_cout_q", 32'(cout_q), 32'd0);
        check("lat_pre_valid_q", 32'(valid_q), 32'd0);
        check("lat_cout_comb", 32'(cout), 32'd1);
        clk_run = 1'b1;
        edge_wait();
        check("lat_cout_q", 32'(cout_q), 32'd1);
        check("lat_s_q", 32'(s_q), 32'd0);
        check("lat_valid_q", 32'(valid_q), 32'd1);

        // Mid-cycle input change: combinational now, registered at next edge.
        a = 1'b0; b = 1'b0; cin = 1'b1;
        #1;
        check("mid_s_comb", 32'(s), 32'd1);
        check("mid_s_q_hold", 32'(s_q), 32'd0);
        check("mid_cout_q_hold", 32'(cout_q), 32'd1);
        edge_wait();
        check("mid_s_q", 32'(s_q), 32'd1);
        check("mid_cout_q", 32'(cout_q), 32'd0);
        check("mid_valid_q", 32'(valid_q), 32'd1);

        // Reset mid-operation while Cout_q is 1.
        a = 1'b1; b = 1'b1; cin = 1'b1;
        edge_wait();
        check("pre_rst_cout_q", 32'(cout_q), 32'd1);
        check("pre_rst_s_q", 32'(s_q), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_s_q", 32'(s_q), 32'd0);
        check("async_rst_cout_q", 32'(cout_q), 32'd0);
        check("async_rst_valid_q", 32'(valid_q), 32'd0);
        check("in_rst_s", 32'(s), 32'd1);
        check("in_rst_cout", 32'(cout), 32'd1);
        a = 1'b0;
        #1;
        check("in_rst_s_track", 32'(s), 32'd0);
        check("in_rst_cout_track", 32'(cout), 32'd1);
        edge_wait();
        check("rst_hold_cout_q", 32'(cout_q), 32'd0);
        check("rst_hold_valid_q", 32'(valid_q), 32'd0);
        // Release between edges with fresh inputs.
        a = 1'b0; b = 1'b1; cin = 1'b0;
        #1;
        rst_n = 1'b1;
        edge_wait();
        check("post_rst_s_q", 32'(s_q), 32'd1);
        check("post_rst_cout_q", 32'(cout_q), 32'd0);
        check("post_rst_valid_q", 32'(valid_q), 32'd1);

`ifdef ADDER_CARRY_CNT_EN
        // Saturation with CNT_W=2: 1,2,3,3,3.
        #1;
        rst_n = 1'b0;
        #1;
        check("sat_rst_cnt", 32'(carry_cnt), 32'd0);
        a = 1'b1; b = 1'b1; cin = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            edge_wait();
            check($sformatf("sat_cnt%0d", k), 32'(carry_cnt), (k < 3) ? 32'(k + 1) : 32'd3);
        end
        a = 1'b0; b = 1'b0;
        edge_wait();
        check("sat_hold_no_carry", 32'(carry_cnt), 32'd3);
`endif

        clk_run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder.md
ADDER -- requirements
Module: adder

Interface
REQ-001 The parameter SHALL be CNT_W, default 8, giving the width of the carry-event counter (legal range 1..32).
REQ-002 The port clk SHALL be input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The port rst_n SHALL be input, 1 bit, the reset; asynchronous, active-low.
REQ-004 The port S SHALL be output, 1 bit, the combinational sum; positional port 1.
REQ-005 The port Cout SHALL be output, 1 bit, the combinational carry-out; positional port 2.
REQ-006 The port A SHALL be input, 1 bit, addend; positional port 3.
REQ-007 The port B SHALL be input, 1 bit, addend; positional port 4.
REQ-008 The port Cin SHALL be input, 1 bit, carry-in; positional port 5.
REQ-009 The ports clk and rst_n SHALL follow Cin positionally, so that a five-port positional instance (S, Cout, A, B, Cin) connects correctly and leaves clk and rst_n unconnected.
REQ-010 The port S_q SHALL be output, 1 bit, the registered copy of S.
REQ-011 The port Cout_q SHALL be output, 1 bit, the registered copy of Cout.
REQ-012 The port valid_q SHALL be output, 1 bit, high once S_q and Cout_q hold a sampled result.
REQ-013 The port carry_cnt SHALL be output, CNT_W bits, the saturating count of carry events; present only with ADDER_CARRY_CNT_EN.

Function
REQ-014 S SHALL equal A xor B xor Cin; Cout SHALL equal (A and B) or (A and Cin) or (B and Cin).
REQ-015 S and Cout SHALL be purely combinational: zero-cycle latency, no clock dependency, and valid regardless of rst_n state.
REQ-016 {Cout,S} SHALL equal the 2-bit arithmetic sum A+B+Cin for all 8 input combinations.
REQ-017 S_q and Cout_q SHALL capture S and Cout on every rising clk edge while rst_n is high (1-cycle latency, no enable).
REQ-018 valid_q SHALL go high at the first rising clk edge with rst_n high and stay high until the next reset.
REQ-019 carry_cnt SHALL increment by 1 on each rising edge where Cout is 1, and saturate at all-ones.
REQ-020 Inputs changing between edges SHALL affect S and Cout immediately but the registered outputs only at the next edge.

Reset
REQ-021 Assertion of rst_n low SHALL immediately, without a clock edge, force S_q=0, Cout_q=0, valid_q=0 and carry_cnt=0.
REQ-022 While rst_n is low, registers SHALL hold their reset values; S and Cout SHALL keep tracking the inputs.
REQ-023 Reset asserted mid-operation SHALL discard all registered state; the first edge after release SHALL sample fresh inputs.

Configuration
REQ-024 With ADDER_CARRY_CNT_EN defined, the carry_cnt port and its counter SHALL exist as specified in REQ-019.
REQ-025 Without ADDER_CARRY_CNT_EN, the carry_cnt port and its counter logic SHALL be absent, with all other behaviour unchanged.

Verification
REQ-026 The exhaustive sweep SHALL apply {A,B,Cin} = 000,010,100,110,001,011,101,111, 1 time unit apart, with no clock; S/Cout SHALL be 0/0, 1/0, 1/0, 0/1, 1/0, 0/1, 0/1, 1/1.
REQ-027 The latency test SHALL apply A=1,B=1,Cin=0 before a rising edge; Cout_q=1, S_q=0 and valid_q=1 SHALL hold after that edge, and not before it.
REQ-028 The reset test SHALL drop rst_n low between edges while Cout_q=1; S_q, Cout_q and valid_q SHALL go 0 at once while S and Cout still follow the inputs.
REQ-029 The saturation test SHALL use CNT_W=2 with ADDER_CARRY_CNT_EN and hold A=B=1 for 5 edges; carry_cnt SHALL read 1,2,3,3,3.
REQ-030 The configuration test SHALL build without ADDER_CARRY_CNT_EN; the carry_cnt port SHALL be absent and REQ-026 to REQ-028 SHALL still pass.
